// File: rtl/axis_fifo_pkg.sv
// Shared sizing helpers for the packet-aware AXI-Stream FIFO.
package axis_fifo_pkg;

  // Pointer width for a circular buffer of 'depth' entries (at least one bit).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of counters that must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Highest valid pointer value; pointers wrap to zero after this.
  function automatic int max_ptr(input int depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/axis_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module axis_fifo_mem #(
  parameter int dw    = 9,
  parameter int depth = 10,
  parameter int aw    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [dw-1:0] wdata,
  input  logic [aw-1:0] raddr,
  output logic [dw-1:0] rdata
);

  logic [dw-1:0] mem_q [depth];

  // Contents are deliberately not reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_fifo_pkt.sv
// AXI-Stream FIFO with last flag, occupancy, thresholds and packet count.
module axis_fifo_pkt
  import axis_fifo_pkg::*;
#(
  parameter int width    = 8,
  parameter int depth    = 10,
  parameter int af_level = 8,
  parameter int ae_level = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [width-1:0]           s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [width-1:0]           m_data,
  output logic                       m_last,
  output logic [$clog2(depth+1)-1:0] level,
  output logic [$clog2(depth+1)-1:0] pkt_count,
  output logic                       almost_full,
  output logic                       almost_empty
);

  localparam int PW = ptr_w(depth);
  localparam int CW = cnt_w(depth);
  localparam logic [PW-1:0] LAST_PTR = PW'(max_ptr(depth));

  typedef struct packed {
    logic             last;
    logic [width-1:0] data;
  } beat_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
  logic [CW-1:0] level_q, level_d, pkt_q, pkt_d;
  logic          full, empty, push, pop, pkt_inc, pkt_dec;
  beat_t         wbeat, rbeat;

  // Equal pointers are disambiguated by the wrap bits.
  assign empty = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q == rd_wrap_q);
  assign full  = (wr_ptr_q == rd_ptr_q) && (wr_wrap_q != rd_wrap_q);

  assign s_ready = !full;
  assign m_valid = !empty;
  assign push    = s_valid && !full;
  assign pop     = m_ready && !empty;

  assign wbeat = '{last: s_last, data: s_data};

  axis_fifo_mem #(
    .dw    (width + 1),
    .depth (depth),
    .aw    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wbeat),
    .raddr (rd_ptr_q),
    .rdata (rbeat)
  );

  assign m_data  = rbeat.data;
  assign m_last  = rbeat.last;
  assign pkt_inc = push && s_last;
  assign pkt_dec = pop && rbeat.last;

  // Next pointers, wrap bits, occupancy and packet count.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    wr_wrap_d = wr_wrap_q;
    rd_ptr_d  = rd_ptr_q;
    rd_wrap_d = rd_wrap_q;
    level_d   = level_q;
    pkt_d     = pkt_q;

    if (push) begin
      if (wr_ptr_q == LAST_PTR) begin
        wr_ptr_d  = '0;
        wr_wrap_d = !wr_wrap_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    if (pop) begin
      if (rd_ptr_q == LAST_PTR) begin
        rd_ptr_d  = '0;
        rd_wrap_d = !rd_wrap_q;
      end else begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end

    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;

    if (pkt_inc && !pkt_dec)      pkt_d = pkt_q + 1'b1;
    else if (!pkt_inc && pkt_dec) pkt_d = pkt_q - 1'b1;
  end

  // State registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      wr_wrap_q <= 1'b0;
      rd_ptr_q  <= '0;
      rd_wrap_q <= 1'b0;
      level_q   <= '0;
      pkt_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      wr_wrap_q <= wr_wrap_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_wrap_q <= rd_wrap_d;
      level_q   <= level_d;
      pkt_q     <= pkt_d;
    end
  end

  assign level        = level_q;
  assign pkt_count    = pkt_q;
  assign almost_full  = (32'(level_q) >= 32'(af_level));
  assign almost_empty = (32'(level_q) <= 32'(ae_level));

endmodule

// File: tb/tb_axis_fifo_pkt.sv
// Self-checking bench for axis_fifo_pkt: directed table, corner sequences, random vs queue model.
module tb_axis_fifo_pkt;

  localparam int W  = 8;
  localparam int D  = 10;
  localparam int AF = 8;
  localparam int AE = 2;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid, s_ready, s_last, m_valid, m_ready, m_last;
  logic [W-1:0]  s_data, m_data;
  logic [CW-1:0] level, pkt_count;
  logic          almost_full, almost_empty;

  always #5 clk = ~clk;

  axis_fifo_pkt #(.width(W), .depth(D), .af_level(AF), .ae_level(AE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .level        (level),
    .pkt_count    (pkt_count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: ordered list of stored {last,data} beats.
  logic [W:0] mq[$];
  bit         prev_stall = 1'b0;
  logic [W:0] prev_beat;

  typedef struct {
    logic         sv;
    logic [W-1:0] d;
    logic         mr;
    int           lvl;
    logic         srdy;
    logic         mval;
    logic [W-1:0] head;
    logic         af;
    logic         ae;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int model_pkts();
    int n = 0;
    foreach (mq[i]) if (mq[i][W]) n++;
    return n;
  endfunction

  task automatic check_model();
    int sz = mq.size();
    chk("level", 32'(level), sz);
    chk("s_ready", 32'(s_ready), (sz < D) ? 1 : 0);
    chk("m_valid", 32'(m_valid), (sz > 0) ? 1 : 0);
    chk("pkt_count", 32'(pkt_count), model_pkts());
    chk("almost_full", 32'(almost_full), (sz >= AF) ? 1 : 0);
    chk("almost_empty", 32'(almost_empty), (sz <= AE) ? 1 : 0);
    if (sz > 0) chk("head", 32'({m_last, m_data}), 32'(mq[0]));
  endtask

  // Drive one cycle at the falling edge, update the model at the rising edge, check at the next fall.
  task automatic step(input logic sv, input logic [W-1:0] d, input logic l, input logic mr);
    bit do_push, do_pop, stall_now;
    s_valid = sv; s_data = d; s_last = l; m_ready = mr;
    #1;
    stall_now = sv && !s_ready;
    if (prev_stall) chk("hold_stable", 32'({s_valid, s_last, s_data}), 32'({1'b1, prev_beat}));
    prev_stall = stall_now;
    prev_beat  = {l, d};
    @(posedge clk);
    do_push = sv && (mq.size() < D);
    do_pop  = mr && (mq.size() > 0);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({l, d});
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    rst_n = 1'b0;
    mq.delete();
    prev_stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int exp_pop;
    int nxt;
    bit pend;
    logic sv, l, mr;
    logic [W-1:0] d;

    // Directed table: fill to full, full with both sides active, refill, drain.
    for (int i = 0; i < 10; i++)
      tbl[i] = '{sv: 1'b1, d: 8'(i), mr: 1'b0, lvl: i + 1, srdy: (i < 9),
                 mval: 1'b1, head: 8'h00, af: (i + 1 >= 8), ae: (i + 1 <= 2)};
    tbl[10] = '{sv: 1'b1, d: 8'h0A, mr: 1'b1, lvl: 9, srdy: 1'b1, mval: 1'b1,
                head: 8'h01, af: 1'b1, ae: 1'b0};
    tbl[11] = '{sv: 1'b1, d: 8'h0A, mr: 1'b0, lvl: 10, srdy: 1'b0, mval: 1'b1,
                head: 8'h01, af: 1'b1, ae: 1'b0};
    for (int j = 0; j < 10; j++)
      tbl[12 + j] = '{sv: 1'b0, d: 8'h00, mr: 1'b1, lvl: 9 - j, srdy: 1'b1, mval: (j < 9),
                      head: (j < 8) ? 8'(j + 2) : 8'h0A, af: (9 - j >= 8), ae: (9 - j <= 2)};

    do_reset();
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_pkt_count", 32'(pkt_count), 0);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_almost_full", 32'(almost_full), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].sv, tbl[i].d, 1'b0, tbl[i].mr);
      chk("tbl_level", 32'(level), tbl[i].lvl);
      chk("tbl_s_ready", 32'(s_ready), 32'(tbl[i].srdy));
      chk("tbl_m_valid", 32'(m_valid), 32'(tbl[i].mval));
      chk("tbl_almost_full", 32'(almost_full), 32'(tbl[i].af));
      chk("tbl_almost_empty", 32'(almost_empty), 32'(tbl[i].ae));
      if (tbl[i].mval) chk("tbl_head", 32'(m_data), 32'(tbl[i].head));
    end

    // Wrap: push 3 / pop 2 rounds so both pointers pass 9->0 several times.
    do_reset();
    nxt = 0;
    exp_pop = 0;
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < 3; k++)
        if (mq.size() < D) begin
          step(1'b1, 8'(nxt), 1'b0, 1'b0);
          nxt++;
        end
      for (int k = 0; k < 2; k++) begin
        chk("wrap_order", 32'(m_data), 32'(8'(exp_pop)));
        step(1'b0, 8'h00, 1'b0, 1'b1);
        exp_pop++;
        chk("wrap_level_max", (32'(level) <= D) ? 1 : 0, 1);
      end
    end
    while (mq.size() > 0) begin
      chk("wrap_order", 32'(m_data), 32'(8'(exp_pop)));
      step(1'b0, 8'h00, 1'b0, 1'b1);
      exp_pop++;
    end
    chk("wrap_all_returned", exp_pop, nxt);

    // Simultaneous push and pop hold the level.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h20 + k), 1'b0, 1'b1);
    chk("simul_level", 32'(level), 5);
    chk("simul_head", 32'(m_data), 32'h14);

    // Packet counting.
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h30 + i), (i == 2 || i == 6), 1'b0);
    chk("pkt_after_fill", 32'(pkt_count), 2);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pkt_third_last", 32'(m_last), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pkt_after_pop3", 32'(pkt_count), 1);
    for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("pkt_head_last", 32'(m_last), 1);
    step(1'b1, 8'h40, 1'b1, 1'b1);
    chk("pkt_concurrent", 32'(pkt_count), 1);

    // Asynchronous reset in the middle of traffic.
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 6);
    s_valid = 1'b0; m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_m_valid", 32'(m_valid), 0);
    chk("async_level", 32'(level), 0);
    chk("async_s_ready", 32'(s_ready), 1);
    chk("async_almost_empty", 32'(almost_empty), 1);
    mq.delete();
    prev_stall = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk("post_rst_first", 32'(m_data), 32'hA5);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Randomized traffic with phases biased towards full and empty.
    pend = 1'b0;
    sv = 1'b0; d = '0; l = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int pv, pr;
      pv = (c % 600 < 300) ? 75 : 35;
      pr = (c % 600 < 300) ? 35 : 75;
      if (!pend) begin
        sv = ($urandom_range(0, 99) < pv);
        d  = 8'($urandom);
        l  = ($urandom_range(0, 3) == 0);
      end
      mr = ($urandom_range(0, 99) < pr);
      pend = sv && (mq.size() >= D);
      step(sv, d, l, mr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
